// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if
//   Bundles the E/D-stage request signals and the HI/LO result signals
//   exchanged between the pipeline and the multiply/divide sequencer.
//   master : pipeline side (drives md_op, start, A, B, md_use_D)
//   slave  : mdu_ctrl side (drives busy, stall, HI, LO)
//   md_op    3  E-stage op code (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo)
//   start    1  E-stage instruction valid
//   A, B     32 forwarded rs / rt values
//   md_use_D 1  D-stage instruction uses the HI/LO resource
//   busy     1  multi-cycle operation in flight
//   stall    1  D-stage stall request
//   HI, LO   32 architectural HI/LO registers
interface mdu_ctrl_if;
    logic [2:0]  md_op;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output md_op, start, A, B, md_use_D,
        input  busy, stall, HI, LO
    );

    modport slave (
        input  md_op, start, A, B, md_use_D,
        output busy, stall, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
//   HI/LO multiply/divide sequencer for the 5-stage pipeline. Accepts
//   mult/multu/div/divu/mthi/mtlo from E, computes the result at the accept
//   edge, holds it for MULT_CYCLES/DIV_CYCLES busy cycles, then commits it
//   to HI/LO. Raises a D-stage stall while a later HI/LO user would collide.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mdu_ctrl_if slave modport (request in, busy/stall/HI/LO out)
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_resHi;
    logic [31:0] r_resLo;

    logic        w_isMulDiv;
    logic        w_accept;
    logic        w_divZero;
    logic        w_divOvf;
    logic [31:0] w_divisor;
    logic [63:0] w_prodU;
    logic [63:0] w_prodS;
    logic [31:0] w_quoS;
    logic [31:0] w_remS;
    logic [31:0] w_quoU;
    logic [31:0] w_remU;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;

    assign w_isMulDiv = (bus.md_op >= 3'd1) && (bus.md_op <= 3'd4);
    assign w_accept   = bus.start && (r_state == S_IDLE) &&
                        (bus.md_op >= 3'd1) && (bus.md_op <= 3'd6);

    // Signed product via explicit sign extension: low 64 bits of the
    // unsigned product of the extended operands equal the signed product.
    assign w_prodU = {32'd0, bus.A} * {32'd0, bus.B};
    assign w_prodS = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};

    // Zero divisor and MIN/-1 are resolved by the result mux below; the
    // divider sees a harmless divisor of 1 in those cases.
    assign w_divZero = (bus.B == 32'd0);
    assign w_divOvf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
    assign w_divisor = (w_divZero || w_divOvf) ? 32'd1 : bus.B;

    assign w_quoS = $signed(bus.A) / $signed(w_divisor);
    assign w_remS = $signed(bus.A) % $signed(w_divisor);
    assign w_quoU = bus.A / w_divisor;
    assign w_remU = bus.A % w_divisor;

    always_comb begin
        w_resHi = w_prodS[63:32];
        w_resLo = w_prodS[31:0];
        case (bus.md_op)
            3'd1: begin
                w_resHi = w_prodS[63:32];
                w_resLo = w_prodS[31:0];
            end
            3'd2: begin
                w_resHi = w_prodU[63:32];
                w_resLo = w_prodU[31:0];
            end
            3'd3: begin
                if (w_divZero) begin
                    w_resHi = bus.A;
                    w_resLo = 32'hFFFF_FFFF;
                end else if (w_divOvf) begin
                    w_resHi = 32'd0;
                    w_resLo = 32'h8000_0000;
                end else begin
                    w_resHi = w_remS;
                    w_resLo = w_quoS;
                end
            end
            3'd4: begin
                if (w_divZero) begin
                    w_resHi = bus.A;
                    w_resLo = 32'hFFFF_FFFF;
                end else begin
                    w_resHi = w_remU;
                    w_resLo = w_quoU;
                end
            end
            default: begin
                w_resHi = w_prodS[63:32];
                w_resLo = w_prodS[31:0];
            end
        endcase
    end

    // Result is latched at accept and committed on the last busy edge, so
    // HI/LO keep the previous values while an operation is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_resHi <= 32'd0;
            r_resLo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_isMulDiv) begin
                            r_resHi <= w_resHi;
                            r_resLo <= w_resLo;
                            r_cnt   <= (bus.md_op <= 3'd2) ? 4'(MULT_CYCLES)
                                                           : 4'(DIV_CYCLES);
                            r_state <= S_RUN;
                        end else if (bus.md_op == 3'd5) begin
                            r_hi <= bus.A;
                        end else begin
                            r_lo <= bus.A;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_resHi;
                        r_lo    <= r_resLo;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = (r_state == S_RUN);
    // Gated by reset so no stall is requested while the unit is held in reset.
    assign bus.stall = reset && bus.md_use_D &&
                       ((r_state == S_RUN) || (bus.start && w_isMulDiv));
    assign bus.HI    = r_hi;
    assign bus.LO    = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
//   Directed self-checking bench for mdu_ctrl: reset, mthi/mtlo, mult/multu,
//   div/divu including divide-by-zero and overflow, stall timing, ignored
//   ops during RUN, back-to-back issue and reset abandoning an operation.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   nChecks;
    int   nErrors;

    mdu_ctrl_if u_if ();

    mdu_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic st,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic use_d);
        u_if.md_op    = op;
        u_if.start    = st;
        u_if.A        = a;
        u_if.B        = b;
        u_if.md_use_D = use_d;
    endtask

    // Single-cycle mthi/mtlo; called at a negedge, returns at a negedge.
    task automatic moveOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] expHi, input logic [31:0] expLo);
        applyStimulus(op, 1'b1, a, 32'd0, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit({tag, "-busy"}, u_if.busy, 1'b0);
        checkWord({tag, "-HI"}, u_if.HI, expHi);
        checkWord({tag, "-LO"}, u_if.LO, expLo);
    endtask

    // Multi-cycle op issued at a negedge: checks stall on the start cycle,
    // busy/stall/old HI-LO for n cycles, then the committed result.
    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input int n,
                         input logic [31:0] oldHi, input logic [31:0] oldLo,
                         input logic [31:0] newHi, input logic [31:0] newLo);
        checkBit({tag, "-idle"}, u_if.busy, 1'b0);
        applyStimulus(op, 1'b1, a, b, use_d);
        #1;
        checkBit({tag, "-stall0"}, u_if.stall, use_d);
        tick();
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, use_d);
        for (int i = 0; i < n; i++) begin
            checkBit({tag, "-busy"}, u_if.busy, 1'b1);
            checkBit({tag, "-stall"}, u_if.stall, use_d);
            checkWord({tag, "-oldHI"}, u_if.HI, oldHi);
            checkWord({tag, "-oldLO"}, u_if.LO, oldLo);
            tick();
        end
        checkBit({tag, "-done"}, u_if.busy, 1'b0);
        checkBit({tag, "-stallEnd"}, u_if.stall, 1'b0);
        checkWord({tag, "-HI"}, u_if.HI, newHi);
        checkWord({tag, "-LO"}, u_if.LO, newLo);
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        reset   = 1'b0;
        applyStimulus(3'd1, 1'b1, 32'd3, 32'd4, 1'b1);

        // Held in reset with a mult request and D-stage user: nothing moves.
        @(negedge clk);
        checkBit("rst-busy", u_if.busy, 1'b0);
        checkBit("rst-stall", u_if.stall, 1'b0);
        checkWord("rst-HI", u_if.HI, 32'd0);
        checkWord("rst-LO", u_if.LO, 32'd0);
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        tick();
        checkBit("post-rst-busy", u_if.busy, 1'b0);

        moveOp("mtlo", 3'd6, 32'h0000_1234, 32'd0, 32'h0000_1234);
        moveOp("mthi", 3'd5, 32'h0000_CAFE, 32'h0000_CAFE, 32'h0000_1234);

        // Op code 7 with start is a no-op.
        applyStimulus(3'd7, 1'b1, 32'h5555_5555, 32'd1, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("op7-busy", u_if.busy, 1'b0);
        checkWord("op7-HI", u_if.HI, 32'h0000_CAFE);
        checkWord("op7-LO", u_if.LO, 32'h0000_1234);

        runOp("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, MULT_N,
              32'h0000_CAFE, 32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runOp("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, MULT_N,
              32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
        runOp("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_N,
              32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu0", 3'd4, 32'd7, 32'd0, 1'b0, DIV_N,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
        runOp("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_N,
              32'd7, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        runOp("stall", 3'd1, 32'd3, 32'd4, 1'b1, MULT_N,
              32'd0, 32'h8000_0000, 32'd0, 32'd12);
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);

        // divu then multu issued in the first IDLE cycle after completion.
        runOp("b2b-divu", 3'd4, 32'd100, 32'd7, 1'b0, DIV_N,
              32'd0, 32'd12, 32'd2, 32'd14);
        runOp("b2b-multu", 3'd2, 32'd3, 32'd5, 1'b0, MULT_N,
              32'd2, 32'd14, 32'd0, 32'd15);

        // mthi presented during RUN is ignored.
        applyStimulus(3'd3, 1'b1, 32'd100, 32'd7, 1'b0);
        tick();
        applyStimulus(3'd5, 1'b1, 32'h0000_DEAD, 32'd0, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        checkBit("runMthi-busy", u_if.busy, 1'b1);
        checkWord("runMthi-HI", u_if.HI, 32'd0);
        for (int i = 0; i < DIV_N - 1; i++) tick();
        checkBit("runMthi-done", u_if.busy, 1'b0);
        checkWord("runMthi-HIres", u_if.HI, 32'd2);
        checkWord("runMthi-LOres", u_if.LO, 32'd14);

        // Reset during the second busy cycle abandons the mult.
        applyStimulus(3'd1, 1'b1, 32'd3, 32'd4, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        checkBit("midRst-pre", u_if.busy, 1'b1);
        reset = 1'b0;
        #1;
        checkBit("midRst-busy", u_if.busy, 1'b0);
        checkWord("midRst-HI", u_if.HI, 32'd0);
        checkWord("midRst-LO", u_if.LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < MULT_N + 2; i++) tick();
        checkBit("afterRst-busy", u_if.busy, 1'b0);
        checkWord("afterRst-HI", u_if.HI, 32'd0);
        checkWord("afterRst-LO", u_if.LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the HI/LO multiply/divide resource of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and runs multi-cycle operations with a down-counter.
- Holds HI/LO and raises a D-stage stall whenever a later HI/LO user would collide with an operation in flight.
- Sits beside the ALU in E; mfhi/mflo read HI/LO combinationally.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset; reset==0 clears all state immediately
md_op  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 treated as none
start  input  1  E-stage instruction valid this cycle, i.e. not a bubble
A  input  32  forwarded rs value
B  input  32  forwarded rt value
md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in flight
stall  output  1  D-stage stall request
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset values: HI=0, LO=0, busy=0, state IDLE, counter=0. stall=0 while reset is low.
- States are IDLE, RUN. Internal result registers rHI and rLO; 4-bit counter cnt.
- Accept condition: start && state==IDLE && md_op in 1..6. Ops presented while RUN are ignored; the stall makes this unreachable in a legal pipeline.
- mult/multu/div/divu accepted at edge t:
  - Compute the result from A/B at edge t and capture it in rHI/rLO.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, and go to RUN.
- RUN:
  - busy=1.
  - On each edge, cnt decrements.
  - On the edge where cnt==1: HI<=rHI, LO<=rLO, state returns to IDLE.
  - Op accepted at edge t gives busy high for exactly N cycles after t. New HI/LO are visible from the cycle after the last busy cycle.
  - The next op may be accepted on that same IDLE cycle.
- mthi/mtlo accepted: HI<=A or LO<=A at the same edge, single cycle, busy stays 0.
- mult: signed 64-bit A*B. multu: unsigned. HI=product[63:32], LO=product[31:0].
- div: signed division, quotient truncated toward zero. LO=quotient, HI=remainder; the remainder takes the sign of the dividend.
- divu: unsigned division.
- Divide by zero (div or divu): LO=32'hFFFFFFFF, HI=A.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- Divide by zero and overflow still take the full DIV_CYCLES.
- stall = md_use_D && (busy || (start && md_op in 1..4)). Purely combinational. Independent of the HI/LO forwarding path.
- HI/LO outputs are registered values only, with no bypass of rHI/rLO. mfhi/mflo are therefore legal only once stall has cleared.
- Reset asserted mid-RUN: the operation is abandoned, HI/LO return to 0, busy drops asynchronously.
- md_op outside 1..6 with start=1: no state change.

Test Plan:
- Reset low mid-run: mult 3*4, then reset=0 at cycle 2 of busy -> busy=0, HI=0, LO=0 immediately; after release, IDLE with no write.
- mult A=0xFFFFFFFF, B=2 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 after 10 cycles.
- Stall and collision:
  - mult started with md_use_D=1 -> stall=1 on the start cycle and for all 5 busy cycles, 0 in the following cycle.
  - An mthi with start=1 during RUN leaves HI unchanged.
- Back-to-back: mtlo A=0x1234 -> LO=0x1234 next cycle with busy=0. A multu issued in the first IDLE cycle after a div completes is accepted; HI/LO then reflect the div result until the multu commits.
